// File: rtl/ahb_master_ctrl.sv
// AHB-Lite master: one single/INCR command at a time; NONSEQ one cycle after accept, done n+2 cycles after accept.
// Hreadyout low stalls address/data phases in place; cmd_ready is low from accept until done.
module ahb_master_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_wdata,
    output logic [31:0]      Haddr,
    output logic [1:0]       Htrans,
    output logic             Hwrite,
    output logic [2:0]       Hsize,
    output logic [2:0]       Hburst,
    output logic [31:0]      Hwdata,
    input  logic             Hreadyout,
    input  logic [1:0]       Hresp,
    input  logic [31:0]      Hrdata,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    typedef enum logic [1:0] {IDLE, ADDR, LAST, ERR1} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [31:0]       wbase_q, wbase_d;
    logic              dph_q, dph_d;
    logic [31:0]       haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic [LEN_W-1:0]  len_norm;
    logic              last_beat;
    logic              dph_err;

    // Zero-length is treated as a single beat; oversize lengths clamp to MAX_LEN.
    always_comb begin
        if (cmd_len == '0) begin
            len_norm = LEN_W'(1);
        end else if (cmd_len > LEN_W'(MAX_LEN)) begin
            len_norm = LEN_W'(MAX_LEN);
        end else begin
            len_norm = cmd_len;
        end
    end

    assign last_beat = (beat_q == len_q - LEN_W'(1));
    assign dph_err   = dph_q && !Hreadyout && (Hresp == RESP_ERR);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wbase_d     = wbase_q;
        dph_d       = dph_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hburst_d    = hburst_q;
        hwdata_d    = hwdata_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                htrans_d = TR_IDLE;
                if (cmd_valid && cmd_ready_q) begin
                    len_d    = len_norm;
                    beat_d   = '0;
                    wbase_d  = cmd_wdata;
                    dph_d    = 1'b0;
                    haddr_d  = cmd_addr;
                    htrans_d = TR_NONSEQ;
                    hwrite_d = cmd_write;
                    hburst_d = (len_norm == LEN_W'(1)) ? BURST_SINGLE : BURST_INCR;
                    err_d    = 1'b0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (dph_err) begin
                    // Cancel the pending address; remaining beats are dropped.
                    htrans_d = TR_IDLE;
                    err_d    = 1'b1;
                    state_d  = ERR1;
                end else if (Hreadyout) begin
                    if (dph_q && !hwrite_q) begin
                        rd_valid_d = (Hresp != RESP_ERR);
                        rd_data_d  = Hrdata;
                    end
                    dph_d = 1'b1;
                    if (hwrite_q) begin
                        hwdata_d = wbase_q + 32'(beat_q);
                    end
                    if (last_beat) begin
                        htrans_d = TR_IDLE;
                        state_d  = LAST;
                    end else begin
                        haddr_d  = haddr_q + 32'd4;
                        htrans_d = TR_SEQ;
                        beat_d   = beat_q + LEN_W'(1);
                    end
                end
            end
            LAST: begin
                htrans_d = TR_IDLE;
                if (dph_err) begin
                    err_d   = 1'b1;
                    state_d = ERR1;
                end else if (Hreadyout) begin
                    if (!hwrite_q) begin
                        rd_valid_d = (Hresp != RESP_ERR);
                        rd_data_d  = Hrdata;
                    end
                    done_d  = 1'b1;
                    dph_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            ERR1: begin
                htrans_d = TR_IDLE;
                if (Hreadyout) begin
                    done_d  = 1'b1;
                    dph_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                htrans_d = TR_IDLE;
                state_d  = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            wbase_q     <= '0;
            dph_q       <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hburst_q    <= BURST_SINGLE;
            hwdata_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wbase_q     <= wbase_d;
            dph_q       <= dph_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign Haddr     = haddr_q;
    assign Htrans    = htrans_q;
    assign Hwrite    = hwrite_q;
    assign Hsize     = 3'b010;
    assign Hburst    = hburst_q;
    assign Hwdata    = hwdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: a small AHB slave model plus a scoreboard monitor.
module tb_ahb_master_ctrl;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [4:0]  cmd_len;
    logic [31:0] Haddr, Hwdata, Hrdata, rd_data;
    logic [1:0]  Htrans, Hresp;
    logic        Hwrite, Hreadyout, rd_valid, done, err;
    logic [2:0]  Hsize, Hburst;

    always #5 Hclk = ~Hclk;

    ahb_master_ctrl #(.MAX_LEN(16), .LEN_W(5)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
        .Hrdata(Hrdata), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  b;
    } abeat_t;

    typedef struct packed {
        logic        e;
        logic [31:0] dly;
    } dexp_t;

    abeat_t      exp_a[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_r[$];
    dexp_t       exp_d[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_done_cyc = -1;

    // Slave model configuration: which data-phase beat stalls or errors.
    int          cfg_stall_idx = -1;
    int          cfg_stall_n   = 0;
    int          cfg_err_idx   = -1;
    logic [31:0] rd_tbl [0:15];

    logic        s_act, s_write, s_err;
    int          s_idx, s_next, s_wait;

    always_comb begin
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        Hrdata    = 32'h0;
        if (s_act) begin
            if (!s_write) Hrdata = rd_tbl[s_idx[3:0]];
            if (s_idx == cfg_err_idx) begin
                Hresp     = 2'b01;
                Hreadyout = s_err;
            end else if (s_idx == cfg_stall_idx && s_wait < cfg_stall_n) begin
                Hreadyout = 1'b0;
            end
        end
    end

    always @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0;
            s_idx <= 0; s_next <= 0; s_wait <= 0;
        end else if (s_act && !Hreadyout) begin
            s_wait <= s_wait + 1;
            s_err  <= 1'b1;
        end else begin
            s_wait <= 0;
            s_err  <= 1'b0;
            if (Htrans[1]) begin
                s_act   <= 1'b1;
                s_write <= Hwrite;
                if (Htrans == 2'b10) begin
                    s_idx <= 0; s_next <= 1;
                end else begin
                    s_idx <= s_next; s_next <= s_next + 1;
                end
            end else begin
                s_act <= 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge Hclk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expected entry (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        abeat_t      ea;
        dexp_t       ed;
        logic        mon_wdp, stall_a, stall_w;
        logic [31:0] p_addr, p_wdata;
        logic [1:0]  p_trans;
        mon_wdp = 1'b0; stall_a = 1'b0; stall_w = 1'b0;
        p_addr = '0; p_wdata = '0; p_trans = '0;
        forever begin
            @(negedge Hclk);
            if (!Hresetn) begin
                mon_wdp = 1'b0; stall_a = 1'b0; stall_w = 1'b0;
            end else begin
                if (stall_a) begin
                    chk("addr_hold", Haddr, p_addr);
                    chk("trans_hold", 32'(Htrans), 32'(p_trans));
                end
                if (stall_w) chk("wdata_hold", Hwdata, p_wdata);
                if (mon_wdp && Hreadyout && Hresp == 2'b00) begin
                    if (exp_w.size() == 0) unexpected("wdata");
                    else chk("wdata", Hwdata, exp_w.pop_front());
                end
                if (Htrans[1] && Hreadyout) begin
                    if (exp_a.size() == 0) unexpected("addr_phase");
                    else begin
                        ea = exp_a.pop_front();
                        chk("haddr", Haddr, ea.a);
                        chk("htrans", 32'(Htrans), 32'(ea.t));
                        chk("hwrite", 32'(Hwrite), 32'(ea.w));
                        chk("hburst", 32'(Hburst), 32'(ea.b));
                        chk("hsize", 32'(Hsize), 32'd2);
                    end
                end
                if (rd_valid) begin
                    if (exp_r.size() == 0) unexpected("rd_valid");
                    else chk("rd_data", rd_data, exp_r.pop_front());
                end
                if (done) begin
                    if (exp_d.size() == 0) unexpected("done");
                    else begin
                        ed = exp_d.pop_front();
                        chk("done_err", 32'(err), 32'(ed.e));
                        chk("done_latency", 32'(cyc - acc_cyc), ed.dly);
                    end
                    last_done_cyc = cyc;
                end
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
                stall_a = !Hreadyout && Hresp == 2'b00 && Htrans != 2'b00;
                stall_w = mon_wdp && !Hreadyout && Hresp == 2'b00;
                if (Hreadyout) mon_wdp = Htrans[1] && Hwrite;
                p_addr = Haddr; p_trans = Htrans; p_wdata = Hwdata;
            end
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic ea_push(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] b);
        abeat_t e;
        e.a = a; e.t = t; e.w = w; e.b = b;
        exp_a.push_back(e);
    endtask

    task automatic ed_push(input logic e, input int dly);
        dexp_t d;
        d.e = e; d.dly = 32'(dly);
        exp_d.push_back(d);
    endtask

    task automatic cfg(input int st_idx, input int st_n, input int er_idx);
        cfg_stall_idx = st_idx; cfg_stall_n = st_n; cfg_err_idx = er_idx;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [4:0] l,
                         input logic [31:0] d, input bit keep, output int acc);
        int n;
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end
        acc = cyc;
        tick();
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic finish_test(input string nm);
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_d.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: %0d done pulses outstanding, required 0", nm, exp_d.size());
            exp_d.delete();
        end
        repeat (2) tick();
        chk({nm, "_addr_left"}, 32'(exp_a.size()), 32'd0);
        chk({nm, "_wdata_left"}, 32'(exp_w.size()), 32'd0);
        chk({nm, "_rdata_left"}, 32'(exp_r.size()), 32'd0);
        exp_a.delete(); exp_w.delete(); exp_r.delete();
    endtask

    initial begin
        int acc1, acc2;
        for (int i = 0; i < 16; i++) rd_tbl[i] = 32'h0;
        Hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
        repeat (3) tick();

        chk("rst_htrans", 32'(Htrans), 32'd0);
        chk("rst_haddr", Haddr, 32'h0);
        chk("rst_hwrite", 32'(Hwrite), 32'd0);
        chk("rst_hwdata", Hwdata, 32'h0);
        chk("rst_hburst", 32'(Hburst), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        Hresetn = 1'b1;
        tick();

        // Single write.
        cfg(-1, 0, -1);
        ea_push(32'h8000_0000, 2'b10, 1'b1, 3'b000);
        exp_w.push_back(32'hA5A5_0001);
        ed_push(1'b0, 3);
        issue(1'b1, 32'h8000_0000, 5'd1, 32'hA5A5_0001, 1'b0, acc1);
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        finish_test("single_wr");

        // 4-beat read, no waits.
        cfg(-1, 0, -1);
        rd_tbl[0] = 32'h11; rd_tbl[1] = 32'h22; rd_tbl[2] = 32'h33; rd_tbl[3] = 32'h44;
        ea_push(32'h8400_0010, 2'b10, 1'b0, 3'b001);
        ea_push(32'h8400_0014, 2'b11, 1'b0, 3'b001);
        ea_push(32'h8400_0018, 2'b11, 1'b0, 3'b001);
        ea_push(32'h8400_001C, 2'b11, 1'b0, 3'b001);
        exp_r.push_back(32'h11); exp_r.push_back(32'h22);
        exp_r.push_back(32'h33); exp_r.push_back(32'h44);
        ed_push(1'b0, 6);
        issue(1'b0, 32'h8400_0010, 5'd4, 32'h0, 1'b0, acc1);
        finish_test("rd4");

        // 4-beat write, beat 2 data stalled two cycles.
        cfg(2, 2, -1);
        ea_push(32'h8800_0000, 2'b10, 1'b1, 3'b001);
        ea_push(32'h8800_0004, 2'b11, 1'b1, 3'b001);
        ea_push(32'h8800_0008, 2'b11, 1'b1, 3'b001);
        ea_push(32'h8800_000C, 2'b11, 1'b1, 3'b001);
        exp_w.push_back(32'h100); exp_w.push_back(32'h101);
        exp_w.push_back(32'h102); exp_w.push_back(32'h103);
        ed_push(1'b0, 8);
        issue(1'b1, 32'h8800_0000, 5'd4, 32'h100, 1'b0, acc1);
        finish_test("wr4_wait");

        // 8-beat read, two-cycle ERROR on beat 3 data.
        cfg(-1, 0, 3);
        for (int i = 0; i < 8; i++) rd_tbl[i] = 32'hD0 + 32'(i);
        ea_push(32'h8C00_0000, 2'b10, 1'b0, 3'b001);
        ea_push(32'h8C00_0004, 2'b11, 1'b0, 3'b001);
        ea_push(32'h8C00_0008, 2'b11, 1'b0, 3'b001);
        ea_push(32'h8C00_000C, 2'b11, 1'b0, 3'b001);
        exp_r.push_back(32'hD0); exp_r.push_back(32'hD1); exp_r.push_back(32'hD2);
        ed_push(1'b1, 7);
        issue(1'b0, 32'h8C00_0000, 5'd8, 32'h0, 1'b0, acc1);
        finish_test("rd8_err");
        chk("err_sticky", 32'(err), 32'd1);

        // Reset during beat 2 of an 8-beat write.
        cfg(-1, 0, -1);
        ea_push(32'h9000_0000, 2'b10, 1'b1, 3'b001);
        ea_push(32'h9000_0004, 2'b11, 1'b1, 3'b001);
        exp_w.push_back(32'h200);
        issue(1'b1, 32'h9000_0000, 5'd8, 32'h200, 1'b0, acc1);
        tick();
        tick();
        Hresetn = 1'b0;
        #1;
        chk("mid_rst_htrans", 32'(Htrans), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        Hresetn = 1'b1;
        tick();
        rd_tbl[0] = 32'hBEEF_0001;
        ea_push(32'h9000_0100, 2'b10, 1'b0, 3'b000);
        exp_r.push_back(32'hBEEF_0001);
        ed_push(1'b0, 3);
        issue(1'b0, 32'h9000_0100, 5'd1, 32'h0, 1'b0, acc1);
        finish_test("post_rst");

        // Back-to-back with cmd_valid held high.
        cfg(-1, 0, -1);
        rd_tbl[0] = 32'h55; rd_tbl[1] = 32'h66;
        ea_push(32'hA000_0000, 2'b10, 1'b1, 3'b001);
        ea_push(32'hA000_0004, 2'b11, 1'b1, 3'b001);
        ea_push(32'hA000_0100, 2'b10, 1'b0, 3'b001);
        ea_push(32'hA000_0104, 2'b11, 1'b0, 3'b001);
        exp_w.push_back(32'h10); exp_w.push_back(32'h11);
        exp_r.push_back(32'h55); exp_r.push_back(32'h66);
        ed_push(1'b0, 4);
        ed_push(1'b0, 4);
        issue(1'b1, 32'hA000_0000, 5'd2, 32'h10, 1'b1, acc1);
        issue(1'b0, 32'hA000_0100, 5'd2, 32'h0, 1'b0, acc2);
        chk("b2b_accept_cycle", 32'(acc2), 32'(last_done_cyc));
        chk("b2b_gap", 32'(acc2 - acc1), 32'd4);
        finish_test("b2b");

        // Zero length treated as single; address wrap at 2^32.
        cfg(-1, 0, -1);
        ea_push(32'hB000_0000, 2'b10, 1'b1, 3'b000);
        exp_w.push_back(32'h77);
        ed_push(1'b0, 3);
        issue(1'b1, 32'hB000_0000, 5'd0, 32'h77, 1'b0, acc1);
        finish_test("len0");
        rd_tbl[0] = 32'h1; rd_tbl[1] = 32'h2;
        ea_push(32'hFFFF_FFFC, 2'b10, 1'b0, 3'b001);
        ea_push(32'h0000_0000, 2'b11, 1'b0, 3'b001);
        exp_r.push_back(32'h1); exp_r.push_back(32'h2);
        ed_push(1'b0, 4);
        issue(1'b0, 32'hFFFF_FFFC, 5'd2, 32'h0, 1'b0, acc1);
        finish_test("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
